// File: rtl/nnl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nnl_pkg
// Purpose  : Shared definitions for the network-output blocks. Contains the
//            argmax scan FSM state encoding, the default class count and an
//            IEEE-754 single-precision "strictly greater than" helper.
// Revision : 1.0 - initial release
// ============================================================================
package nnl_pkg;

  localparam int NUM_CLASSES_DEF = 7;

  // fp32 field positions
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_MAG_MSB  = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_e;

  // Strict a > b for non-NaN fp32 values. +0 and -0 compare equal.
  function automatic logic fp32_gt(input logic [31:0] a, input logic [31:0] b);
    logic                  sa;
    logic                  sb;
    logic [FP32_MAG_MSB:0] ma;
    logic [FP32_MAG_MSB:0] mb;
    sa = a[FP32_SIGN_BIT];
    sb = b[FP32_SIGN_BIT];
    ma = a[FP32_MAG_MSB:0];
    mb = b[FP32_MAG_MSB:0];
    if ((ma == '0) && (mb == '0)) begin
      return 1'b0;
    end
    if (sa != sb) begin
      return !sa;
    end
    if (!sa) begin
      return (ma > mb);
    end
    // both negative: smaller magnitude is the larger value
    return (ma < mb);
  endfunction

endpackage : nnl_pkg
`default_nettype wire

// File: rtl/fp32_gt_cmp.sv
`default_nettype none
// ============================================================================
// Module   : fp32_gt_cmp
// Purpose  : Combinational fp32 "strictly greater than" comparator.
// Ports    : a  - fp32 operand
//            b  - fp32 operand
//            gt - 1 when a > b (+0 == -0; NaN inputs give unspecified result)
// Revision : 1.0 - initial release
// ============================================================================
module fp32_gt_cmp
  import nnl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  assign gt = fp32_gt(a, b);

endmodule : fp32_gt_cmp
`default_nettype wire

// File: rtl/class_argmax.sv
`default_nettype none
// ============================================================================
// Module   : class_argmax
// Purpose  : Sequential argmax over NUM_CLASSES fp32 class scores using one
//            comparator. Reports the winning index and its score.
// Ports    : clk        - clock
//            rst        - asynchronous active-low reset
//            Data_In    - packed score vector, class k at [k*W +: W]
//            Valid_In   - single-cycle qualifier for Data_In
//            Ready      - high when Valid_In will be accepted
//            Class_Out  - index of maximum score (lowest index on ties)
//            Score_Out  - maximum score value
//            Valid_Out  - one-cycle pulse when results update
//            Class2_Out - index of second-largest score (optional)
//            Overrun    - sticky, Valid_In seen while busy scanning
// Options  : CLASS_ARGMAX_TOP2_EN - adds Class2_Out and second-place tracking
// Revision : 1.0 - initial release
// ============================================================================
module class_argmax
  import nnl_pkg::*;
#(
  parameter int DATA_WIDHT  = 32,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDHT*NUM_CLASSES-1:0] Data_In,
  input  logic                              Valid_In,
  output logic                              Ready,
  output logic [IDX_W-1:0]                  Class_Out,
  output logic [DATA_WIDHT-1:0]             Score_Out,
  output logic                              Valid_Out,
`ifdef CLASS_ARGMAX_TOP2_EN
  output logic [IDX_W-1:0]                  Class2_Out,
`endif
  output logic                              Overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_e          state_q, state_d;
  logic [DATA_WIDHT-1:0]  vec_q [NUM_CLASSES];
  logic [DATA_WIDHT-1:0]  vec_d [NUM_CLASSES];
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDHT-1:0]  best_q, best_d;
  logic [IDX_W-1:0]       best_idx_q, best_idx_d;
  logic [IDX_W-1:0]       class_q, class_d;
  logic [DATA_WIDHT-1:0]  score_q, score_d;
  logic                   ovr_q, ovr_d;

  logic [DATA_WIDHT-1:0]  cand;
  logic                   cand_gt_best;

  assign cand = vec_q[cnt_q];

  fp32_gt_cmp u_cmp_best (
    .a  (cand),
    .b  (best_q),
    .gt (cand_gt_best)
  );

`ifdef CLASS_ARGMAX_TOP2_EN
  logic [DATA_WIDHT-1:0]  sec_q, sec_d;
  logic [IDX_W-1:0]       sec_idx_q, sec_idx_d;
  // Low until a real runner-up exists; until then the initial element-0
  // entry is displaced by any candidate that does not beat the leader.
  logic                   sec_vld_q, sec_vld_d;
  logic [IDX_W-1:0]       class2_q, class2_d;
  logic                   cand_gt_sec;

  fp32_gt_cmp u_cmp_sec (
    .a  (cand),
    .b  (sec_q),
    .gt (cand_gt_sec)
  );

  assign Class2_Out = class2_q;
`endif

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    score_d    = score_q;
    ovr_d      = ovr_q | (Valid_In && (state_q == ST_SCAN));
`ifdef CLASS_ARGMAX_TOP2_EN
    sec_d      = sec_q;
    sec_idx_d  = sec_idx_q;
    sec_vld_d  = sec_vld_q;
    class2_d   = class2_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Valid_In) begin
          for (int k = 0; k < NUM_CLASSES; k++) begin
            vec_d[k] = Data_In[k*DATA_WIDHT +: DATA_WIDHT];
          end
          best_d     = Data_In[DATA_WIDHT-1:0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
`ifdef CLASS_ARGMAX_TOP2_EN
          sec_d      = Data_In[DATA_WIDHT-1:0];
          sec_idx_d  = '0;
          sec_vld_d  = 1'b0;
`endif
          state_d    = ST_SCAN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (cand_gt_best) begin
          best_d     = cand;
          best_idx_d = cnt_q;
`ifdef CLASS_ARGMAX_TOP2_EN
          sec_d      = best_q;
          sec_idx_d  = best_idx_q;
          sec_vld_d  = 1'b1;
        end else if (!sec_vld_q || cand_gt_sec) begin
          sec_d      = cand;
          sec_idx_d  = cnt_q;
          sec_vld_d  = 1'b1;
`endif
        end
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          // final compare folds straight into the result registers
          class_d  = best_idx_d;
          score_d  = best_d;
`ifdef CLASS_ARGMAX_TOP2_EN
          class2_d = sec_idx_d;
`endif
          state_d  = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      for (int k = 0; k < NUM_CLASSES; k++) begin
        vec_q[k] <= '0;
      end
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      score_q    <= '0;
      ovr_q      <= 1'b0;
`ifdef CLASS_ARGMAX_TOP2_EN
      sec_q      <= '0;
      sec_idx_q  <= '0;
      sec_vld_q  <= 1'b0;
      class2_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      score_q    <= score_d;
      ovr_q      <= ovr_d;
`ifdef CLASS_ARGMAX_TOP2_EN
      sec_q      <= sec_d;
      sec_idx_q  <= sec_idx_d;
      sec_vld_q  <= sec_vld_d;
      class2_q   <= class2_d;
`endif
    end
  end

  assign Ready     = (state_q != ST_SCAN);
  assign Valid_Out = (state_q == ST_DONE);
  assign Class_Out = class_q;
  assign Score_Out = score_q;
  assign Overrun   = ovr_q;

endmodule : class_argmax
`default_nettype wire

// File: doc/class_argmax.md
# class_argmax

Consumer of the final layer's class-score vector: it accepts the `NUM_CLASSES` packed 32-bit IEEE-754 single-precision scores produced after global average pooling. It scans the scores sequentially with a single comparator and reports the index of the largest score together with the score value. It sits at the network output, between the last layer's `Data_Out`/`Valid_Out` and the result/host interface.

## Interface
- `DATA_WIDHT`, 32, width of one score (IEEE-754 single).
- `NUM_CLASSES`, 7, number of scores in `Data_In`; valid range 2..16.
- `IDX_W`, `$clog2(NUM_CLASSES)`, width of class index outputs.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-low reset.
- `Data_In`  in  `DATA_WIDHT*NUM_CLASSES`  score vector; class k at bits `[k*DATA_WIDHT +: DATA_WIDHT]`.
- `Valid_In`  in  1  single-cycle qualifier for `Data_In`.
- `Ready`  out  1  high when a `Valid_In` will be accepted.
- `Class_Out`  out  `IDX_W`  index of the maximum score.
- `Score_Out`  out  `DATA_WIDHT`  maximum score value.
- `Valid_Out`  out  1  one-cycle pulse when `Class_Out`/`Score_Out` update.
- `Overrun`  out  1  sticky; set when `Valid_In` arrives while `Ready` is low.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE or DONE with `Valid_In`:**
  - capture the full vector into a local register;
  - set `best` ← element 0, `best_idx` ← 0, scan counter ← 1;
  - go to SCAN.
- **DONE without `Valid_In`:** go to IDLE.
- **SCAN, each cycle:**
  - compare element[counter] with `best`;
  - if strictly greater, replace `best`/`best_idx`;
  - increment counter;
  - on counter == `NUM_CLASSES`-1 (after its compare), go to DONE.
- **Entry to DONE:**
  - `Class_Out`/`Score_Out` take the final winner;
  - `Valid_Out` is high for exactly the DONE cycle.
- **`Ready`:** high in IDLE and DONE, low in SCAN.
- **`Valid_In` while in SCAN:**
  - ignored;
  - the scan in progress is unaffected;
  - `Overrun` ← 1 and stays set until reset.
- **Comparison (fp32 "greater than"):**
  - Signs differ: the non-negative operand is greater, except +0 and -0 are equal.
  - Both positive: compare bits [30:0] unsigned.
  - Both negative: the smaller magnitude is greater.
- **Ties:** the lowest index wins, because replacement requires strictly greater.
- **NaN:** inputs are guaranteed non-NaN by upstream; result for NaN is unspecified.
- **Hold behaviour:** `Class_Out`/`Score_Out` hold their last result until the next DONE.
- **Reset values:**
  - `Class_Out`=0, `Score_Out`=0, `Valid_Out`=0, `Overrun`=0, `Ready`=1;
  - FSM in IDLE;
  - capture register and scan state cleared.

## Timing
- Accept at cycle T (`Valid_In`=1, `Ready`=1).
- SCAN occupies T+1 .. T+`NUM_CLASSES`-1.
- `Valid_Out` is high at cycle T+`NUM_CLASSES` (7 for the default).
- Latency is `NUM_CLASSES` cycles; maximum throughput is one vector per `NUM_CLASSES` cycles.
- Back-to-back: `Valid_In` in the DONE cycle is accepted; its result appears `NUM_CLASSES` cycles later.
- `Data_In` is sampled only in the accept cycle; upstream need not hold it.
- Reset asserted mid-SCAN:
  - immediate return to reset values;
  - no `Valid_Out` for the aborted vector.
  - The first `Valid_In` after deassertion is accepted normally.

## Configuration
- Macro `CLASS_ARGMAX_TOP2_EN`.
- **Defined:**
  - adds output `Class2_Out` (`IDX_W`), the index of the second-largest score, updated with `Class_Out`;
  - when `best` is replaced, the old `best` is demoted to second place;
  - otherwise the candidate replaces second place if strictly greater than the current second;
  - second place is initialised at accept to index 0 with score = element 0, and is demoted out on the first replacement;
  - if element 0 remains the maximum, second place resolves among indices 1..N-1 using the same tie rule: the lowest index wins.
  - Reset value is 0.
- **Undefined:** the port and logic are absent; behaviour is otherwise identical.

## Structure
- **Shared package `nnl_pkg`:**
  - FSM state encoding;
  - `fp32_gt` function or constants for the sign/exponent/mantissa fields;
  - default `NUM_CLASSES`.
- **One sub-module `fp32_gt_cmp`:** combinational, inputs a and b, output `gt`. It is instantiated once, or twice under `CLASS_ARGMAX_TOP2_EN`, and is reusable by pooling/ReLU blocks.

## Test plan
- Scores {1.0, 2.5, -3.0, 7.25, 0.5, 7.0, 6.0} → `Valid_Out` at T+7, `Class_Out`=3, `Score_Out`=0x40E80000; with TOP2, `Class2_Out`=5.
- All negative {-1,-2,-0.5,-8,-3,-0.75,-4} → `Class_Out`=2, `Score_Out`=0xBF000000.
- Ties: all scores 1.0 → `Class_Out`=0; scores {+0,-0,...all -1} → `Class_Out`=0.
- Second `Valid_In` at T+3 → ignored, `Overrun`=1, exactly one `Valid_Out`; a second `Valid_In` exactly at T+7 → accepted, second `Valid_Out` at T+14, `Overrun` stays 0.
- Reset pulse at T+4 → no `Valid_Out`, all outputs 0, `Ready`=1; a new vector after reset gives correct result 7 cycles later.
- Random 1000 non-NaN vectors checked against a reference model (argmax with lowest-index tie rule); `Ready` never low outside SCAN.
